// File: rtl/btn_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : btn_event_fifo
// Description : Turns one-cycle button press pulses into button-index event
//               codes and queues them in press order for a valid/ready
//               consumer. Presses that cannot be held are flagged in a
//               sticky overflow bit.
// Ports       : clk      - system clock, rising edge
//               clr      - asynchronous reset, active-low
//               press    - one-cycle press pulses, bit i = button i
//               ev_ready - consumer accepts the head event this cycle
//               ev_valid - queue non-empty, ev_code valid
//               ev_code  - index of the oldest queued press (0 when empty)
//               count    - entries currently queued (0..DEPTH)
//               ovf      - sticky: at least one press was dropped
//               ovf_clr  - synchronous clear of ovf
// Revision    : 1.0 - initial release
// ============================================================================
module btn_event_fifo #(
    parameter int NBTN  = 4,
    parameter int CW    = 2,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [NBTN-1:0] press,
    input  logic            ev_ready,
    output logic            ev_valid,
    output logic [CW-1:0]   ev_code,
    output logic [AW:0]     count,
    output logic            ovf,
    input  logic            ovf_clr
);

    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    logic [NBTN-1:0] r_pend;
    logic [CW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic            r_ovf;

    logic            w_valid;
    logic            w_pop;
    logic            w_room;
    logic [NBTN-1:0] w_lowest;
    logic [NBTN-1:0] w_grant;
    logic            w_push;
    logic [CW-1:0]   w_code;
    logic            w_drop;

    assign w_valid  = (r_count != '0);
    assign w_pop    = w_valid & ev_ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_room   = (r_count != C_FULL) | w_pop;
    // Two's-complement trick isolates the lowest set bit of the pending mask.
    assign w_lowest = r_pend & (~r_pend + NBTN'(1));
    assign w_grant  = w_room ? w_lowest : '0;
    assign w_push   = |w_grant;
    // A repeat press on a bit that is still pending cannot be recorded.
    assign w_drop   = |(press & r_pend & ~w_grant);

    always_comb begin
        w_code = '0;
        for (int i = 0; i < NBTN; i++) begin
            if (w_grant[i]) begin
                w_code = CW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_pend  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_grant) | press;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            // A fresh drop takes priority over a clear in the same cycle.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_code;
        end
    end

    assign ev_valid = w_valid;
    assign ev_code  = w_valid ? r_mem[r_rptr] : '0;
    assign count    = r_count;
    assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_event_fifo
// Description : Directed self-checking bench for btn_event_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_event_fifo;

    logic       clk;
    logic       clr;
    logic [3:0] press;
    logic       ev_ready;
    logic       ev_valid;
    logic [1:0] ev_code;
    logic [3:0] count;
    logic       ovf;
    logic       ovf_clr;

    int n_checks;
    int n_errors;

    btn_event_fifo #(
        .NBTN  (4),
        .CW    (2),
        .DEPTH (8),
        .AW    (3)
    ) u_dut (
        .clk      (clk),
        .clr      (clr),
        .press    (press),
        .ev_ready (ev_ready),
        .ev_valid (ev_valid),
        .ev_code  (ev_code),
        .count    (count),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Eight single presses cycling through buttons 0..3, then one cycle so the
    // last pending bit is written: queue holds 0,1,2,3,0,1,2,3.
    task automatic fill8();
        for (int k = 0; k < 8; k++) begin
            press = 4'(1 << (k % 4));
            tick();
        end
        press = 4'b0000;
        tick();
    endtask

    task automatic drain(input string tag, input int e[8], input int n);
        ev_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            chk({tag, "_valid"}, int'(ev_valid), 1);
            chk({tag, "_code"},  int'(ev_code),  e[k]);
            tick();
        end
        ev_ready = 1'b0;
        chk({tag, "_empty"}, int'(ev_valid), 0);
        chk({tag, "_cnt0"},  int'(count),    0);
    endtask

    initial begin
        int e2[8];
        int e3[8];
        int e4[8];
        int e6[8];
        int p4[6];
        int pop4[6];

        e2   = '{0, 1, 3, 0, 0, 0, 0, 0};
        e3   = '{1, 2, 3, 0, 1, 2, 3, 1};
        e4   = '{2, 3, 3, 2, 1, 0, 3, 2};
        e6   = '{0, 1, 0, 0, 0, 0, 0, 0};
        p4   = '{3, 2, 1, 0, 3, 2};
        pop4 = '{0, 1, 2, 3, 0, 1};

        n_checks = 0;
        n_errors = 0;
        clr      = 1'b0;
        press    = 4'b0000;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;

        // ---- 1: reset state, single press latency, single pop
        tick();
        tick();
        chk("rst_valid", int'(ev_valid), 0);
        chk("rst_code",  int'(ev_code),  0);
        chk("rst_count", int'(count),    0);
        chk("rst_ovf",   int'(ovf),      0);
        clr = 1'b1;
        tick();
        press = 4'b0100;
        tick();
        press = 4'b0000;
        chk("t1_lat1_valid", int'(ev_valid), 0);
        tick();
        chk("t1_valid", int'(ev_valid), 1);
        chk("t1_code",  int'(ev_code),  2);
        chk("t1_count", int'(count),    1);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        chk("t1_pop_valid", int'(ev_valid), 0);
        chk("t1_pop_count", int'(count),    0);
        chk("t1_pop_code",  int'(ev_code),  0);

        // ---- 2: simultaneous presses queue lowest index first
        press = 4'b1011;
        tick();
        press = 4'b0000;
        tick();
        chk("t2_cnt1", int'(count), 1);
        tick();
        chk("t2_cnt2", int'(count), 2);
        tick();
        chk("t2_cnt3", int'(count), 3);
        tick();
        chk("t2_cnt_hold", int'(count), 3);
        drain("t2", e2, 3);
        chk("t2_ovf", int'(ovf), 0);

        // ---- 3: full queue, pending hold, repeat press drop
        fill8();
        chk("t3_full_cnt",   int'(count),    8);
        chk("t3_full_valid", int'(ev_valid), 1);
        chk("t3_full_code",  int'(ev_code),  0);
        press = 4'b0010;
        tick();
        press = 4'b0000;
        tick();
        chk("t3_pend_cnt", int'(count), 8);
        chk("t3_pend_ovf", int'(ovf),   0);
        press = 4'b0010;
        tick();
        press = 4'b0000;
        chk("t3_drop_ovf", int'(ovf), 1);
        ev_ready = 1'b1;
        chk("t3_head", int'(ev_code), 0);
        tick();
        ev_ready = 1'b0;
        chk("t3_refill_cnt", int'(count), 8);
        drain("t3", e3, 8);

        // ---- 6: ovf_clr without and with a coincident drop
        chk("t6_ovf_pre", int'(ovf), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t6_clr", int'(ovf), 0);
        press = 4'b0011;
        tick();
        press   = 4'b0010;
        ovf_clr = 1'b1;
        tick();
        press   = 4'b0000;
        ovf_clr = 1'b0;
        chk("t6_drop_wins", int'(ovf), 1);
        tick();
        chk("t6_cnt", int'(count), 2);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t6_clr2", int'(ovf), 0);
        drain("t6", e6, 2);

        // ---- 4: full queue with simultaneous push and pop
        fill8();
        for (int i = 0; i < 7; i++) begin
            press    = (i < 6) ? 4'(1 << p4[i]) : 4'b0000;
            ev_ready = (i > 0);
            if (i > 0) begin
                chk("t4_pop_code", int'(ev_code), pop4[i-1]);
            end
            tick();
            chk("t4_cnt", int'(count), 8);
        end
        press    = 4'b0000;
        ev_ready = 1'b0;
        chk("t4_ovf", int'(ovf), 0);
        drain("t4", e4, 8);

        // ---- 5: asynchronous reset mid-operation
        for (int k = 0; k < 5; k++) begin
            press = 4'(1 << (k % 4));
            tick();
        end
        press = 4'b0000;
        tick();
        chk("t5_cnt5", int'(count), 5);
        press = 4'b0110;
        tick();
        press = 4'b0100;
        tick();
        press = 4'b0000;
        chk("t5_cnt6", int'(count), 6);
        chk("t5_ovf",  int'(ovf),   1);
        #2;
        clr = 1'b0;
        #1;
        chk("t5_rst_cnt",   int'(count),    0);
        chk("t5_rst_valid", int'(ev_valid), 0);
        chk("t5_rst_ovf",   int'(ovf),      0);
        chk("t5_rst_code",  int'(ev_code),  0);
        tick();
        clr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_no_stale_valid", int'(ev_valid), 0);
            chk("t5_no_stale_cnt",   int'(count),    0);
        end
        press = 4'b1000;
        tick();
        press = 4'b0000;
        tick();
        chk("t5_post_valid", int'(ev_valid), 1);
        chk("t5_post_code",  int'(ev_code),  3);
        chk("t5_post_cnt",   int'(count),    1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
